// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, prices and default timing for the vending controller
package vend_pkg;
  typedef enum logic [2:0] {
    IDLE, SEL_CANDY, SEL_SODA, DISP_CANDY, CHANGE_CANDY, DISP_SODA, REFUND
  } state_t;
  localparam logic [1:0] CANDY_Q = 2'd1;
  localparam logic [1:0] SODA_Q = 2'd2;
  localparam int DEF_DEBOUNCE = 1_000_000;
  localparam int DEF_HOLD = 200_000_000;
endpackage

// File: rtl/vend_if.sv
// vend_if: vending controller pin bundle
// Inputs:  raw buttons btn_candy/btn_soda/btn_cancel and coin sensors coin_quarter/coin_half
// Outputs: price/change levels, dispense pulses, refund pulse with refund_amt in quarters
interface vend_if;
  logic btn_candy;
  logic btn_soda;
  logic btn_cancel;
  logic coin_quarter;
  logic coin_half;
  logic candy_price;
  logic soda_price;
  logic candy_change_left;
  logic dispense_candy;
  logic dispense_soda;
  logic refund_pulse;
  logic [1:0] refund_amt;
  modport master (
    output btn_candy, btn_soda, btn_cancel, coin_quarter, coin_half,
    input  candy_price, soda_price, candy_change_left, dispense_candy, dispense_soda,
           refund_pulse, refund_amt
  );
  modport slave (
    input  btn_candy, btn_soda, btn_cancel, coin_quarter, coin_half,
    output candy_price, soda_price, candy_change_left, dispense_candy, dispense_soda,
           refund_pulse, refund_amt
  );
endinterface

// File: rtl/vend_debounce.sv
// vend_debounce: 2-flop synchronizer, stability counter and rising-edge event for one raw input
// Ports: CLK, RST (async, active-high), raw_i (asynchronous level), ev_o (one-cycle press event)
module vend_debounce
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_i,
  output logic ev_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, stb_q, ev_q;
  logic [CW-1:0] cnt_q;
  logic done;
  assign done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  assign ev_o = ev_q;
  // stb_q resets high so a button held through reset must be released before it can fire
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      stb_q <= 1'b1;
      cnt_q <= '0;
      ev_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      ev_q <= done && s2_q && !stb_q;
      if (s2_q == stb_q) cnt_q <= '0;
      else if (done) begin
        cnt_q <= '0;
        stb_q <= s2_q;
      end else cnt_q <= cnt_q + CW'(1);
    end
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: candy/soda vending controller with debounced inputs, quarter credit and timed results
// Ports: CLK, RST (async, active-high), bus (vend_if.slave: raw inputs in, price/dispense/refund out)
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int HOLD_CYCLES = DEF_HOLD
) (
  input logic CLK,
  input logic RST,
  vend_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [4:0] raw, ev;
  logic [1:0] coin_amt, val, sum;
  state_t state_q;
  logic [1:0] credit_q, refund_amt_q;
  logic [HW-1:0] hold_q;
  logic candy_price_q, soda_price_q, change_q, disp_candy_q, disp_soda_q, refund_q;
  assign raw = {bus.coin_half, bus.coin_quarter, bus.btn_cancel, bus.btn_soda, bus.btn_candy};
  for (genvar g = 0; g < 5; g++) begin : g_db
    vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK(CLK), .RST(RST), .raw_i(raw[g]), .ev_o(ev[g])
    );
  end
  // coin refunds return every coin seen; for payment the half outranks the quarter
  assign coin_amt = {ev[4], ev[3]};
  assign val = ev[4] ? 2'd2 : 2'd1;
  assign sum = credit_q + val;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      credit_q <= '0;
      hold_q <= '0;
      candy_price_q <= 1'b0;
      soda_price_q <= 1'b0;
      change_q <= 1'b0;
      disp_candy_q <= 1'b0;
      disp_soda_q <= 1'b0;
      refund_q <= 1'b0;
      refund_amt_q <= '0;
    end else begin
      candy_price_q <= state_q == SEL_CANDY;
      soda_price_q <= state_q == SEL_SODA;
      change_q <= state_q == CHANGE_CANDY;
      disp_candy_q <= 1'b0;
      disp_soda_q <= 1'b0;
      refund_q <= 1'b0;
      refund_amt_q <= '0;
      hold_q <= hold_q + HW'(1);
      case (state_q)
        IDLE: begin
          if (ev[0]) state_q <= SEL_CANDY;
          else if (ev[1]) state_q <= SEL_SODA;
          if (|coin_amt) begin
            refund_q <= 1'b1;
            refund_amt_q <= coin_amt;
          end
        end
        SEL_CANDY: begin
          if (ev[2]) state_q <= IDLE;
          else if (|coin_amt) begin
            state_q <= val > CANDY_Q ? CHANGE_CANDY : DISP_CANDY;
            disp_candy_q <= 1'b1;
            hold_q <= '0;
          end
        end
        SEL_SODA: begin
          if (ev[2]) begin
            state_q <= credit_q != '0 ? REFUND : IDLE;
            refund_q <= credit_q != '0;
            refund_amt_q <= credit_q;
            credit_q <= '0;
            hold_q <= '0;
          end else if (|coin_amt) begin
            if (sum < SODA_Q) credit_q <= sum;
            else if (sum == SODA_Q) begin
              state_q <= DISP_SODA;
              disp_soda_q <= 1'b1;
              credit_q <= '0;
              hold_q <= '0;
            end else begin
              refund_q <= 1'b1;
              refund_amt_q <= val;
            end
          end
        end
        default: begin
          if (|coin_amt) begin
            refund_q <= 1'b1;
            refund_amt_q <= coin_amt;
          end
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            state_q <= IDLE;
            credit_q <= '0;
          end
        end
      endcase
    end
  assign bus.candy_price = candy_price_q;
  assign bus.soda_price = soda_price_q;
  assign bus.candy_change_left = change_q;
  assign bus.dispense_candy = disp_candy_q;
  assign bus.dispense_soda = disp_soda_q;
  assign bus.refund_pulse = refund_q;
  assign bus.refund_amt = refund_amt_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scenario tasks with a pulse scoreboard for vend_ctrl
module tb_vend_ctrl;
  localparam logic [4:0] CANDY = 5'b00001, SODA = 5'b00010, CANCEL = 5'b00100, QTR = 5'b01000, HALF = 5'b10000;
  localparam logic [3:0] EV_CANDY = 4'b0100, EV_SODA = 4'b1000, REF1 = 4'b1101, REF2 = 4'b1110;
  logic CLK, RST;
  logic [4:0] raw;
  int checks, errors, chg_cnt;
  logic [3:0] exp_q[$];
  logic [3:0] o, e;
  logic [2:0] p;
  vend_if bus();
  assign bus.btn_candy = raw[0];
  assign bus.btn_soda = raw[1];
  assign bus.btn_cancel = raw[2];
  assign bus.coin_quarter = raw[3];
  assign bus.coin_half = raw[4];
  vend_ctrl #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (!RST) begin
    if (bus.candy_change_left) chg_cnt++;
    p = {bus.refund_pulse, bus.dispense_soda, bus.dispense_candy};
    for (int k = 0; k < 3; k++) if (p[k]) begin
      o = k == 0 ? EV_CANDY : k == 1 ? EV_SODA : {2'b11, bus.refund_amt};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse: got event %b, want none", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL pulse: got event %b, want %b", o, e);
        end
      end
    end
    checks++;
    if (!bus.refund_pulse && bus.refund_amt !== 2'd0) begin
      errors++;
      $display("FAIL refund_amt_idle: got %0d, want 0", bus.refund_amt);
    end
    checks++;
    if ($countones({bus.candy_price, bus.soda_price, bus.candy_change_left}) > 1) begin
      errors++;
      $display("FAIL onehot: got %b, want at most one", {bus.candy_price, bus.soda_price, bus.candy_change_left});
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end
  task automatic press(input logic [4:0] m, input int hi = 8, input int lo = 7);
    raw = m;
    repeat (hi) @(negedge CLK);
    raw = '0;
    repeat (lo) @(negedge CLK);
  endtask
  task automatic chk(input string n, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", n, got, want);
    end
  endtask
  task automatic drained(input string n);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d outstanding, want 0", n, exp_q.size());
      exp_q.delete();
    end
  endtask
  function automatic logic [3:0] lv();
    return {bus.refund_pulse, bus.candy_change_left, bus.soda_price, bus.candy_price};
  endfunction
  task automatic test_reset;
    raw = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({lv(), bus.dispense_candy, bus.dispense_soda, bus.refund_amt} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 0", {lv(), bus.dispense_candy, bus.dispense_soda, bus.refund_amt});
    end
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    chk("after_reset", lv(), 4'b0000);
  endtask
  task automatic test_idle_refund;
    exp_q.push_back(REF1);
    press(QTR);
    exp_q.push_back(REF2);
    press(HALF);
    press(CANCEL);
    chk("idle_levels", lv(), 4'b0000);
    drained("idle_refund");
  endtask
  task automatic test_candy;
    press(CANDY);
    chk("candy_sel", lv(), 4'b0001);
    exp_q.push_back(EV_CANDY);
    press(QTR);
    chk("candy_disp", lv(), 4'b0000);
    repeat (20) @(negedge CLK);
    press(SODA);
    chk("candy_then_idle", lv(), 4'b0010);
    press(CANCEL);
    chk("cancel_zero", lv(), 4'b0000);
    drained("candy");
  endtask
  task automatic test_candy_change;
    press(CANDY);
    exp_q.push_back(EV_CANDY);
    chg_cnt = 0;
    press(HALF);
    chk("change_level", lv(), 4'b0100);
    repeat (20) @(negedge CLK);
    checks++;
    if (chg_cnt != 16) begin
      errors++;
      $display("FAIL change_cycles: got %0d, want 16", chg_cnt);
    end
    drained("candy_change");
  endtask
  task automatic test_soda;
    press(SODA);
    press(QTR);
    chk("soda_credit1", lv(), 4'b0010);
    exp_q.push_back(EV_SODA);
    press(QTR);
    chk("soda_disp", lv(), 4'b0000);
    repeat (20) @(negedge CLK);
    drained("soda");
  endtask
  task automatic test_soda_reject;
    press(SODA);
    press(QTR);
    exp_q.push_back(REF2);
    press(HALF);
    chk("reject_stays", lv(), 4'b0010);
    exp_q.push_back(EV_SODA);
    press(QTR);
    chk("reject_credit_kept", lv(), 4'b0000);
    repeat (20) @(negedge CLK);
    drained("soda_reject");
  endtask
  task automatic test_cancel_refund;
    press(SODA);
    press(QTR);
    press(CANCEL, 2, 10);
    chk("glitch_ignored", lv(), 4'b0010);
    exp_q.push_back(REF1);
    press(CANCEL, 8, 0);
    press(CANDY);
    chk("refund_ignores_sel", lv(), 4'b0000);
    repeat (10) @(negedge CLK);
    press(CANDY);
    chk("refund_then_idle", lv(), 4'b0001);
    press(CANCEL);
    drained("cancel_refund");
  endtask
  task automatic test_priority;
    press(CANDY | SODA);
    chk("both_sel_candy", lv(), 4'b0001);
    press(CANCEL);
    press(SODA);
    press(QTR);
    exp_q.push_back(REF1);
    press(CANCEL | HALF);
    chk("cancel_over_half", lv(), 4'b0000);
    repeat (20) @(negedge CLK);
    press(CANDY);
    exp_q.push_back(EV_CANDY);
    chg_cnt = 0;
    press(QTR | HALF);
    repeat (20) @(negedge CLK);
    checks++;
    if (chg_cnt != 16) begin
      errors++;
      $display("FAIL half_over_quarter: got %0d change cycles, want 16", chg_cnt);
    end
    drained("priority");
  endtask
  task automatic test_back_to_back;
    press(SODA);
    exp_q.push_back(EV_SODA);
    press(HALF);
    exp_q.push_back(REF1);
    press(QTR);
    repeat (20) @(negedge CLK);
    press(CANDY);
    chk("b2b_candy", lv(), 4'b0001);
    press(CANCEL);
    drained("back_to_back");
  endtask
  task automatic test_reset_mid;
    press(SODA);
    press(QTR);
    chk("mid_sel_soda", lv(), 4'b0010);
    raw = SODA;
    #3 RST = 1'b1;
    #1;
    checks++;
    if ({lv(), bus.dispense_candy, bus.dispense_soda, bus.refund_amt} !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got %b, want 0", {lv(), bus.dispense_candy, bus.dispense_soda, bus.refund_amt});
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("held_no_event", lv(), 4'b0000);
    raw = '0;
    repeat (10) @(negedge CLK);
    press(SODA);
    chk("repress_soda", lv(), 4'b0010);
    press(CANCEL);
    chk("credit_discarded", lv(), 4'b0000);
    drained("reset_mid");
  endtask
  initial begin
    checks = 0;
    errors = 0;
    chg_cnt = 0;
    test_reset;
    test_idle_refund;
    test_candy;
    test_candy_change;
    test_soda;
    test_soda_reject;
    test_cancel_refund;
    test_priority;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles required before a button/coin press is accepted (10 ms at 100 MHz).
REQ-002 Parameter HOLD_CYCLES, default 200_000_000, cycles a dispense/change/refund result is held before returning to idle (2 s).
REQ-003 CLK  input  1  system clock, 100 MHz.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 btn_candy  input  1  raw candy select button, asynchronous, active-high.
REQ-006 btn_soda  input  1  raw soda select button, asynchronous, active-high.
REQ-007 btn_cancel  input  1  raw cancel button, asynchronous, active-high.
REQ-008 coin_quarter  input  1  raw 25c coin sensor, asynchronous, active-high.
REQ-009 coin_half  input  1  raw 50c coin sensor, asynchronous, active-high.
REQ-010 candy_price  output  1  level; candy selected, 0.25 owed; feeds the seven-segment driver.
REQ-011 soda_price  output  1  level; soda selected, 0.50 price shown; feeds the seven-segment driver.
REQ-012 candy_change_left  output  1  level; 0.25 change being returned after candy overpay.
REQ-013 dispense_candy  output  1  one-cycle pulse, release candy.
REQ-014 dispense_soda  output  1  one-cycle pulse, release soda.
REQ-015 refund_pulse  output  1  one-cycle pulse, return coin(s); paired with refund_amt.
REQ-016 refund_amt  output  2  credit returned, in quarters (1 = 0.25, 2 = 0.50); valid while refund_pulse is high, 0 otherwise.

Function
REQ-017 Each raw input SHALL pass a 2-flop synchronizer, then a debouncer; an event pulse of one cycle SHALL be produced on a debounced 0->1 transition only, with one event per press.
REQ-018 Credit SHALL be held in a 2-bit register counting quarters, range 0..2.
REQ-019 States SHALL be IDLE, SEL_CANDY, SEL_SODA, DISP_CANDY, CHANGE_CANDY, DISP_SODA, REFUND.
REQ-020 IDLE: candy event -> SEL_CANDY; soda event -> SEL_SODA; both in the same cycle -> SEL_CANDY; coin events SHALL be refunded immediately (refund_pulse, refund_amt 1 or 2), and the state SHALL remain IDLE.
REQ-021 SEL_CANDY: quarter -> DISP_CANDY; half -> CHANGE_CANDY; cancel with credit 0 -> IDLE.
REQ-022 SEL_SODA: quarter with credit 0 -> credit 1; quarter with credit 1 -> DISP_SODA; half with credit 0 -> DISP_SODA; half with credit 1 SHALL be rejected (refund_pulse, refund_amt 2, credit unchanged, state unchanged).
REQ-023 Cancel in SEL_SODA with credit > 0 -> REFUND, with refund_pulse and refund_amt = credit issued on entry; cancel with credit 0 -> IDLE, no pulse.
REQ-024 Same-cycle priority in SEL states SHALL be cancel > half > quarter; lower-priority events in that cycle SHALL be discarded and not refunded.
REQ-025 Select events in SEL states SHALL be ignored. All events in DISP_CANDY, CHANGE_CANDY, DISP_SODA and REFUND SHALL be ignored, except coins, which SHALL be refunded as in IDLE.
REQ-026 dispense_candy SHALL pulse in the first cycle of DISP_CANDY and of CHANGE_CANDY. dispense_soda SHALL pulse in the first cycle of DISP_SODA.
REQ-027 A hold counter SHALL clear on entry to each result state; after HOLD_CYCLES cycles in that state -> IDLE with credit 0.
REQ-028 candy_price SHALL be high iff the state is SEL_CANDY; soda_price iff SEL_SODA; candy_change_left iff CHANGE_CANDY. These are registered outputs, at most one high, updating one cycle after the transition.
REQ-029 Latency from the debounced event to the state change SHALL be 1 cycle.

Reset
REQ-030 RST SHALL force the state to IDLE, clear credit, the hold counter, debounce counters and synchronizers, and drive all outputs to 0, asynchronously.
REQ-031 RST asserted mid-transaction SHALL discard credit without a refund pulse.
REQ-032 A button held through reset release SHALL NOT generate an event until it is released and pressed again.

Structure
REQ-033 Package vend_pkg SHALL hold the state encoding, the price constants (CANDY_Q = 1, SODA_Q = 2 quarters) and the default timing constants.
REQ-034 Sub-module debounce (synchronizer, counter, edge detect, DEBOUNCE_CYCLES parameter) SHALL be instantiated five times.

Verification (bench uses DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 16)
REQ-035 candy press, then quarter -> candy_price high until the coin; dispense_candy pulses once; IDLE after 16 cycles.
REQ-036 candy press, then half -> candy_change_left high for 16 cycles; one dispense_candy pulse; no refund.
REQ-037 soda press, quarter, quarter -> credit 1 then DISP_SODA; one dispense_soda pulse; soda_price low after the second coin.
REQ-038 soda press, quarter, half -> refund_pulse with refund_amt = 2; state stays SEL_SODA; credit = 1.
REQ-039 soda press, quarter, cancel -> refund_pulse with refund_amt = 1; state REFUND for 16 cycles, then IDLE; 2-cycle glitch on btn_cancel yields no event.
REQ-040 RST asserted in SEL_SODA with credit 1 -> all outputs 0 immediately, no refund pulse; btn_soda held across reset release gives no event.
